// File: rtl/seg7_pkg.sv
// Shared definitions for the result display: segment glyphs, conversion FSM states
// and the hex-to-segment lookup. Glyphs are active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_4     = 7'b1100110;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1111101;
    localparam logic [6:0] GLYPH_7     = 7'b0000111;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1101111;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_B     = 7'b1111100;
    localparam logic [6:0] GLYPH_C     = 7'b0111001;
    localparam logic [6:0] GLYPH_D     = 7'b1011110;
    localparam logic [6:0] GLYPH_E     = 7'b1111001;
    localparam logic [6:0] GLYPH_F     = 7'b1110001;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    localparam logic [2:0] LAST_ITER = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] glyph;
        case (hex)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            default: glyph = GLYPH_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a 6-bit binary value into two BCD digits
// over six shift cycles, followed by a one-cycle DONE state.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] units
);

    conv_state_e state_q, state_d;
    logic [2:0]  iter_q, iter_d;
    logic [13:0] shift_q, shift_d;
    logic [13:0] adjusted;
    logic [3:0]  tensAdj, unitsAdj;

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        shift_d  = shift_q;
        tensAdj  = (shift_q[13:10] >= 4'd5) ? shift_q[13:10] + 4'd3 : shift_q[13:10];
        unitsAdj = (shift_q[9:6] >= 4'd5) ? shift_q[9:6] + 4'd3 : shift_q[9:6];
        adjusted = {tensAdj, unitsAdj, shift_q[5:0]};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = {8'd0, bin};
                    iter_d  = 3'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = adjusted << 1;
                if (iter_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end else begin
                    iter_d = iter_q + 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            iter_q  <= 3'd0;
            shift_q <= 14'd0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            shift_q <= shift_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign tens  = shift_q[13:10];
    assign units = shift_q[9:6];

endmodule

// File: rtl/result_7seg_driver.sv
// Shows the operator selector's op code and 6-bit result on a 4-digit
// common-anode display as [op][blank][tens][units].
module result_7seg_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter bit SEG_ACT_LOW = 1'b1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] result_in,
    input  logic [2:0] op_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy
);

    localparam int               CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]       AN_OFF  = SEG_ACT_LOW ? 4'hF : 4'h0;

    logic [5:0]       resMeta_q, resSync_q, lastConv_q, lastConv_d;
    logic [2:0]       opMeta_q, opSync_q, opHold_q, opHold_d, opDisp_q, opDisp_d;
    logic             pending_q, pending_d;
    logic [3:0]       dispTens_q, dispTens_d, dispUnits_q, dispUnits_d;
    logic [CNT_W-1:0] scanCnt_q, scanCnt_d;
    logic [1:0]       scanIdx_q, scanIdx_d;
    logic [6:0]       seg_q, seg_d, segRaw;
    logic [3:0]       an_q, an_d, anRaw;
    logic             startConv, convBusy, convDone;
    logic [3:0]       convTens, convUnits;

    // Switch inputs are asynchronous to clk and need two flops before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resMeta_q <= 6'd0;
            resSync_q <= 6'd0;
            opMeta_q  <= 3'd0;
            opSync_q  <= 3'd0;
        end else begin
            resMeta_q <= result_in;
            resSync_q <= resMeta_q;
            opMeta_q  <= op_in;
            opSync_q  <= opMeta_q;
        end
    end

    always_comb begin
        lastConv_d  = lastConv_q;
        opHold_d    = opHold_q;
        pending_d   = pending_q;
        opDisp_d    = opDisp_q;
        dispTens_d  = dispTens_q;
        dispUnits_d = dispUnits_q;
        startConv   = !convBusy && (pending_q || (resSync_q != lastConv_q));
        if (startConv) begin
            lastConv_d = resSync_q;
            opHold_d   = opSync_q;
            pending_d  = 1'b0;
        end
        // The op digit tracks the switches while idle, but a finished conversion
        // shows the op that was captured together with its result.
        if (convDone) begin
            dispTens_d  = convTens;
            dispUnits_d = convUnits;
            opDisp_d    = opHold_q;
        end else if (!convBusy) begin
            opDisp_d = opSync_q;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (startConv),
        .bin   (resSync_q),
        .busy  (convBusy),
        .done  (convDone),
        .tens  (convTens),
        .units (convUnits)
    );

    always_comb begin
        scanCnt_d = scanCnt_q + CNT_W'(1);
        scanIdx_d = scanIdx_q;
        if (scanCnt_q == CNT_MAX) begin
            scanCnt_d = '0;
            scanIdx_d = scanIdx_q + 2'd1;
        end
    end

    always_comb begin
        anRaw = 4'b0001 << scanIdx_q;
        case (scanIdx_q)
            2'd0: segRaw = hex_to_seg(dispUnits_q);
            2'd1: segRaw = (dispTens_q == 4'd0) ? GLYPH_BLANK : hex_to_seg(dispTens_q);
            2'd2: segRaw = GLYPH_BLANK;
            default: segRaw = hex_to_seg({1'b0, opDisp_q});
        endcase
        seg_d = SEG_ACT_LOW ? ~segRaw : segRaw;
        an_d  = SEG_ACT_LOW ? ~anRaw : anRaw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastConv_q  <= 6'd0;
            opHold_q    <= 3'd0;
            pending_q   <= 1'b1;
            opDisp_q    <= 3'd0;
            dispTens_q  <= 4'd0;
            dispUnits_q <= 4'd0;
            scanCnt_q   <= '0;
            scanIdx_q   <= 2'd0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            lastConv_q  <= lastConv_d;
            opHold_q    <= opHold_d;
            pending_q   <= pending_d;
            opDisp_q    <= opDisp_d;
            dispTens_q  <= dispTens_d;
            dispUnits_q <= dispUnits_d;
            scanCnt_q   <= scanCnt_d;
            scanIdx_q   <= scanIdx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = SEG_ACT_LOW ? 1'b1 : 1'b0;
    assign busy = convBusy;

endmodule
